// File: rtl/load_unit_pkg.sv
// load_unit_pkg: size codes, FSM encoding and size helper shared by the load path
package load_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    return sz == SZ_BYTE ? 2'd0 : sz == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/load_unit_extend.sv
// load_extend: orders the captured bytes and zero/sign-extends them to 32 bits
module load_extend
  import load_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] i_buf,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  logic [15:0] w_half;
  logic [31:0] w_word;
  assign {w_b3, w_b2, w_b1, w_b0} = i_buf;
  assign w_half = BIG_ENDIAN ? {w_b0, w_b1} : {w_b1, w_b0};
  assign w_word = BIG_ENDIAN ? {w_b0, w_b1, w_b2, w_b3} : i_buf;
  // reserved size 2'b11 falls through to the word case
  always_comb begin
    o_data = i_size == SZ_BYTE ? {{24{i_sext & w_b0[7]}}, w_b0} :
             i_size == SZ_HALF ? {{16{i_sext & w_half[15]}}, w_half} : w_word;
  end
endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle byte-serial load engine with extension and done pulse
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  input  logic [7:0]            mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data
);
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [1:0]            r_size, r_count;
  logic                  r_sext;
  logic [31:0]           r_buf, r_load_data, w_buf_next, w_ext;
  logic                  w_last;
  assign w_last    = r_count == last_idx(r_size);
  assign load_data = r_load_data;
  // buffer with the byte arriving this cycle dropped into its slot
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_count, 3'b000} +: 8] = mem_read_data;
  end
  load_extend #(.BIG_ENDIAN(BIG_ENDIAN)) u_ext (
    .i_buf (w_buf_next),
    .i_size(r_size),
    .i_sext(r_sext),
    .o_data(w_ext)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  // next-state: start only matters in IDLE, DONE always returns to IDLE
  always_comb begin
    w_next = r_state == S_IDLE ? (start ? S_READ : S_IDLE) :
             r_state == S_READ ? (w_last ? S_DONE : S_READ) : S_IDLE;
  end
  // outputs decoded from state; the memory port is read-only here
  always_comb begin
    busy             = r_state == S_READ;
    done             = r_state == S_DONE;
    mem_write_enable = 1'b0;
    mem_address      = r_state == S_READ ? r_base + ADDR_WIDTH'(r_count) : '0;
  end
  // request latch, byte capture and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_size      <= SZ_BYTE;
      r_sext      <= 1'b0;
      r_count     <= 2'd0;
      r_buf       <= '0;
      r_load_data <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_base  <= address;
      r_size  <= size;
      r_sext  <= sign_ext;
      r_count <= 2'd0;
      r_buf   <= '0;
    end else if (r_state == S_READ) begin
      r_buf   <= w_buf_next;
      r_count <= w_last ? r_count : r_count + 2'd1;
      if (w_last) r_load_data <= w_ext;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed table-driven check of load_unit against a byte memory model
module tb_load_unit;
  logic        clk = 1'b0;
  logic        reset, start, sign_ext;
  logic [15:0] address, mem_address;
  logic [1:0]  size;
  logic        mem_write_enable, busy, done;
  logic [7:0]  mem_read_data;
  logic [31:0] load_data;
  logic [7:0]  mem [65536];
  logic [31:0] prev;
  int          tests = 0, fails = 0;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address];

  load_unit dut (
    .clk(clk), .reset(reset), .start(start), .address(address), .size(size),
    .sign_ext(sign_ext), .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .busy(busy), .done(done), .load_data(load_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic [1:0] sz, input logic sx,
                         input logic [31:0] exp, input logic poke);
    int n;
    logic [15:0] ea;
    n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    @(negedge clk);
    address = a; size = sz; sign_ext = sx; start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = poke;
      if (poke) begin address = 16'h0020; size = 2'b00; sign_ext = 1'b0; end
      ea = a + 16'(i);
      chk("busy_read", 32'(busy), 32'd1);
      chk("done_read", 32'(done), 32'd0);
      chk("addr_step", 32'(mem_address), 32'(ea));
      chk("stale_data", load_data, prev);
      chk("we_low", 32'(mem_write_enable), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("addr_done", 32'(mem_address), 32'd0);
    chk("load_data", load_data, exp);
    prev = exp;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("held_data", load_data, exp);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hFF;
    mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56;
    mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12; mem[16'h0014] = 8'h9A;
    mem[16'h0020] = 8'h00; mem[16'h0021] = 8'h80;
    vecs[0] = '{16'h0000, 2'b00, 1'b1, 32'hFFFFFFFF};
    vecs[1] = '{16'h0000, 2'b00, 1'b0, 32'h000000FF};
    vecs[2] = '{16'h0010, 2'b10, 1'b0, 32'h12345678};
    vecs[3] = '{16'h0010, 2'b11, 1'b1, 32'h12345678};
    vecs[4] = '{16'h0020, 2'b01, 1'b1, 32'hFFFF8000};
    vecs[5] = '{16'h0020, 2'b01, 1'b0, 32'h00008000};
    vecs[6] = '{16'h0011, 2'b01, 1'b1, 32'h00003456};
    vecs[7] = '{16'h0013, 2'b00, 1'b1, 32'h00000012};
    vecs[8] = '{16'h0011, 2'b10, 1'b1, 32'h9A123456};
    vecs[9] = '{16'h0021, 2'b00, 1'b1, 32'hFFFFFF80};
    reset = 1'b1; start = 1'b0; address = '0; size = '0; sign_ext = 1'b0;
    prev = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", load_data, 32'h0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    reset = 1'b0;
    for (int v = 0; v < 10; v++) do_load(vecs[v].addr, vecs[v].sz, vecs[v].sx, vecs[v].exp, 1'b0);
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'hCC;
    do_load(16'hFFFE, 2'b10, 1'b0, 32'hCCBBAA11, 1'b0);
    do_load(16'h0010, 2'b10, 1'b0, 32'h12345678, 1'b1);
    @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);
    address = 16'h0010; size = 2'b10; sign_ext = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_addr2", 32'(mem_address), 32'h0011);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_data", load_data, 32'h0);
    chk("abort_addr", 32'(mem_address), 32'd0);
    prev = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    do_load(16'h0020, 2'b01, 1'b1, 32'hFFFF8000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle load engine for the execution-cycle datapath; the read-side counterpart of the byte-wide store path.
- Takes the ALU-computed effective address and a size code.
- Reads 1, 2 or 4 consecutive bytes from the 8-bit-wide byte-addressed memory, one byte per clock.
- Assembles them little-endian, zero- or sign-extends to 32 bits, and presents the result with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 16, width of the memory byte address.
- BIG_ENDIAN, 0, byte-assembly order: 0 = first byte read lands in bits [7:0]; 1 = first byte read lands in the most significant byte of the loaded size.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a load; sampled only in IDLE.
- address  input  ADDR_WIDTH  effective byte address (ALU result, low bits).
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- sign_ext  input  1  1 = sign-extend sub-word loads; 0 = zero-extend.
- mem_address  output  ADDR_WIDTH  address to memory read port.
- mem_write_enable  output  1  held 0 so the shared memory port never writes during a load.
- mem_read_data  input  8  memory read data, combinational from mem_address.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when load_data is valid.
- load_data  output  32  assembled, extended result; held until the next accepted start.

Behaviour:
- Reset (async, any state): FSM to IDLE; busy=0, done=0, load_data=32'h0, mem_address=0, byte counter=0, internal byte buffer cleared. mem_write_enable is 0 always.
- States: IDLE, READ, DONE.
- IDLE:
  - mem_address=0.
  - On an edge with start=1: latch address into base, latch size and sign_ext, set count=0, go to READ.
  - N is 1, 2 or 4 from the latched size.
- READ:
  - busy=1; mem_address = base + count, computed modulo 2^ADDR_WIDTH (address 16'hFFFF + 1 wraps to 16'h0000).
  - Each edge captures mem_read_data into byte slot count.
  - If count == N-1, go to DONE; otherwise count++.
- DONE (one cycle):
  - done=1, busy=0, mem_address=0.
  - load_data updated on entry with the extended value:
    - byte: bits[31:8] = sign_ext ? {24{b0[7]}} : 0
    - half: bits[31:16] = sign_ext ? {16{msb}} : 0
    - word: no extension
  - Next state is IDLE unconditionally.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+N, i.e. 2, 3 or 5 cycles after start for byte, half or word.
- start while busy or in DONE: ignored, no queuing. Inputs address, size and sign_ext may change freely after acceptance.
- load_data changes only on entry to DONE or on reset. Stale data remains visible between loads.
- Unaligned addresses are legal: no alignment check, bytes are read sequentially.
- Reset asserted mid-READ: load aborted, no done pulse, load_data=0.
- size=11: identical to size=10.

Decomposition:
- Shared package/header, used by the ALU, memory and load_unit benches:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encodings S_IDLE, S_READ, S_DONE.
- Sub-module load_extend: combinational, takes the 4-byte buffer, latched size, sign_ext and BIG_ENDIAN, and produces the 32-bit result.
- The FSM and counter stay in load_unit.

Test Plan:
- Memory 0x0000=FF; start, address=0x0000, size=00, sign_ext=1 -> done after 2 cycles; load_data=32'hFFFFFFFF. Repeat with sign_ext=0 -> 32'h000000FF.
- Memory 0x0010..0x0013 = 78,56,34,12; size=10 -> mem_address steps 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles; done on the 5th cycle; load_data=32'h12345678.
- Memory 0x0020=00, 0x0021=80; size=01, sign_ext=1 -> 32'hFFFF8000; sign_ext=0 -> 32'h00008000.
- Memory 0xFFFF=AA, 0x0000=BB; address=0xFFFE, size=10 -> mem_address sequence FFFE, FFFF, 0000, 0001 (wrap-around); load_data bytes [15:8]=AA, [23:16]=BB.
- start pulsed again during READ of a word load -> ignored; exactly one done; busy pattern unchanged.
- Reset asserted on the 2nd READ cycle -> immediate IDLE; busy=0, load_data=0, no done pulse. Next load completes normally.
